sponge_ctrl: RTL

SPONGE_CTRL -- requirements
Module: sponge_ctrl

---
 rtl/sponge_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sponge_ctrl.sv
// sponge_ctrl: sequences message blocks through an external sponge absorb
// datapath and presents the final digest.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   blk_valid/ready     message block handshake (blk_data, blk_last)
//   abs_go              one-cycle start strobe to the absorb datapath
//   abs_data_o/r_o/c_o  latched block and rate/capacity state to datapath
//   abs_ready           datapath completion, with abs_r_i/abs_c_i results
//   digest_valid/ack    digest handshake, digest = rate[511:0]
//   abort               synchronous soft clear
//   busy, err, blk_cnt  status
module sponge_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [575:0] blk_data,
    input  logic         blk_last,
    output logic         abs_go,
    output logic [575:0] abs_data_o,
    output logic [575:0] abs_r_o,
    output logic [1023:0] abs_c_o,
    input  logic         abs_ready,
    input  logic [575:0] abs_r_i,
    input  logic [1023:0] abs_c_i,
    output logic         digest_valid,
    output logic [511:0] digest,
    input  logic         digest_ack,
    input  logic         abort,
    output logic         busy,
    output logic         err,
    output logic [15:0]  blk_cnt
);

    localparam int unsigned RATE_W = 576;
    localparam int unsigned CAP_W  = 1024;
    localparam int unsigned DIG_W  = 512;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // Last RUN cycle index (counter starts at 0 on the first RUN cycle).
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2:0]        state_q,        state_d;
    logic [RATE_W-1:0] blk_q,          blk_d;
    logic              last_q,         last_d;
    logic [RATE_W-1:0] rate_q,         rate_d;
    logic [CAP_W-1:0]  cap_q,          cap_d;
    logic [CNT_W-1:0]  cnt_q,          cnt_d;
    logic [TMO_W-1:0]  tmo_q,          tmo_d;
    logic              blk_ready_q,    blk_ready_d;
    logic              abs_go_q,       abs_go_d;
    logic              digest_valid_q, digest_valid_d;
    logic              busy_q,         busy_d;
    logic              err_q,          err_d;

    logic accept_c;

    // A block is taken only while the registered ready is high (IDLE/NEXT).
    assign accept_c = blk_valid && blk_ready_q;

    // Next-state and datapath register update.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        last_d  = last_q;
        rate_d  = rate_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE, S_NEXT: begin
                // Rate/capacity are kept across NEXT so the datapath chains.
                if (accept_c) begin
                    blk_d   = blk_data;
                    last_d  = blk_last;
                    state_d = S_START;
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Completion wins over timeout on the final allowed cycle.
                if (abs_ready) begin
                    rate_d  = abs_r_i;
                    cap_d   = abs_c_i;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = last_q ? S_DONE : S_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                if (digest_ack) begin
                    rate_d  = '0;
                    cap_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Soft clear overrides everything above.
        if (abort) begin
            state_d = S_IDLE;
            blk_d   = '0;
            last_d  = 1'b0;
            rate_d  = '0;
            cap_d   = '0;
            cnt_d   = '0;
            tmo_d   = '0;
        end
    end

    // Status outputs are decoded from the next state so they flop in
    // alignment with state_q.
    always_comb begin
        blk_ready_d    = (state_d == S_IDLE) || (state_d == S_NEXT);
        abs_go_d       = (state_d == S_START);
        digest_valid_d = (state_d == S_DONE);
        busy_d         = (state_d == S_START) || (state_d == S_RUN) ||
                         (state_d == S_NEXT)  || (state_d == S_DONE);
        err_d          = (state_d == S_ERR);
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            blk_q          <= '0;
            last_q         <= 1'b0;
            rate_q         <= '0;
            cap_q          <= '0;
            cnt_q          <= '0;
            tmo_q          <= '0;
            blk_ready_q    <= 1'b1;
            abs_go_q       <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            blk_q          <= blk_d;
            last_q         <= last_d;
            rate_q         <= rate_d;
            cap_q          <= cap_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            blk_ready_q    <= blk_ready_d;
            abs_go_q       <= abs_go_d;
            digest_valid_q <= digest_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign blk_ready    = blk_ready_q;
    assign abs_go       = abs_go_q;
    assign abs_data_o   = blk_q;
    assign abs_r_o      = rate_q;
    assign abs_c_o      = cap_q;
    assign digest_valid = digest_valid_q;
    assign digest       = rate_q[DIG_W-1:0];
    assign busy         = busy_q;
    assign err          = err_q;
    assign blk_cnt      = cnt_q;

endmodule
